// File: rtl/tap_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tap_pkg
// Brief   : Shared TAP encodings, opcodes and DR-select enum.
// Rev     : 1.0
// ============================================================================
package tap_pkg;

  typedef enum logic [3:0] {
    TS_TEST_LOGIC_RESET = 4'h0,
    TS_RUN_TEST_IDLE    = 4'h1,
    TS_SELECT_DR        = 4'h2,
    TS_CAPTURE_DR       = 4'h3,
    TS_SHIFT_DR         = 4'h4,
    TS_EXIT1_DR         = 4'h5,
    TS_PAUSE_DR         = 4'h6,
    TS_EXIT2_DR         = 4'h7,
    TS_UPDATE_DR        = 4'h8,
    TS_SELECT_IR        = 4'h9,
    TS_CAPTURE_IR       = 4'hA,
    TS_SHIFT_IR         = 4'hB,
    TS_EXIT1_IR         = 4'hC,
    TS_PAUSE_IR         = 4'hD,
    TS_EXIT2_IR         = 4'hE,
    TS_UPDATE_IR        = 4'hF
  } tap_state_e;

  // Opcodes are sized to 32 bits and cast down to IR_WIDTH at the use site.
  localparam logic [31:0] OP_BYPASS = '1;
  localparam logic [31:0] OP_IDCODE = 32'd1;
  localparam logic [31:0] OP_USER   = 32'd2;

  localparam logic [1:0] IR_CAPTURE_PATTERN = 2'b01;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

endpackage
`default_nettype wire

// File: rtl/tap_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : tap_shift_reg
// Brief   : Generic capture/shift register, shifts right with tdi into MSB.
// Rev     : 1.0
// ============================================================================
module tap_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             tclk,
  input  logic             trst,
  input  logic             capture,
  input  logic             shift,
  input  logic [WIDTH-1:0] capture_val,
  input  logic             tdi,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shift_d;

  generate
    if (WIDTH == 1) begin : g_single
      assign shift_d = tdi;
    end else begin : g_multi
      assign shift_d = {tdi, q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      q <= '0;
    end else if (capture) begin
      q <= capture_val;
    end else if (shift) begin
      q <= shift_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tap_scan_regs.sv
`default_nettype none
// ============================================================================
// Module  : tap_scan_regs
// Brief   : JTAG IR plus BYPASS/IDCODE/USER DRs; USER DR built with TAP_USER_REG_EN.
// Rev     : 1.0
// ============================================================================
module tap_scan_regs
  import tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1234_5093,
  parameter int unsigned USER_WIDTH   = 8
) (
  input  logic                  tclk,
  input  logic                  trst,
  input  logic                  tdi,
  input  logic                  test_logic_reset,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  input  logic                  capture_ir,
  input  logic                  shift_ir,
  input  logic                  update_ir,
  input  logic [USER_WIDTH-1:0] user_in,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [IR_WIDTH-1:0]   ir_out,
  output logic [USER_WIDTH-1:0] user_out,
  output logic                  user_update
);

  // Decodes are one-hot by contract; the masks enforce the documented priority.
  logic upd_ir_en, upd_dr_en, cap_ir_en, cap_dr_en, sh_ir_en, sh_dr_en;
  assign upd_ir_en = update_ir  & ~test_logic_reset;
  assign upd_dr_en = update_dr  & ~test_logic_reset & ~update_ir;
  assign cap_ir_en = capture_ir & ~test_logic_reset & ~update_ir & ~update_dr;
  assign cap_dr_en = capture_dr & ~test_logic_reset & ~update_ir & ~update_dr & ~capture_ir;
  assign sh_ir_en  = shift_ir   & ~test_logic_reset & ~update_ir & ~update_dr & ~capture_ir
                                & ~capture_dr;
  assign sh_dr_en  = shift_dr   & ~test_logic_reset & ~update_ir & ~update_dr & ~capture_ir
                                & ~capture_dr & ~shift_ir;

  logic [IR_WIDTH-1:0] ir_shift_q, ir_out_q, ir_out_d;
  logic [31:0]         id_shift_q;
  logic                bypass_q, bypass_d;
  logic                user_lsb;
  logic                unused_bits;
  dr_sel_e             dr_sel;

  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_out_q == IR_WIDTH'(OP_IDCODE)) dr_sel = DR_IDCODE;
`ifdef TAP_USER_REG_EN
    if (ir_out_q == IR_WIDTH'(OP_USER)) dr_sel = DR_USER;
`endif
  end

  tap_shift_reg #(.WIDTH(IR_WIDTH)) u_ir_shift (
    .tclk        (tclk),
    .trst        (trst),
    .capture     (cap_ir_en),
    .shift       (sh_ir_en),
    .capture_val (IR_WIDTH'(IR_CAPTURE_PATTERN)),
    .tdi         (tdi),
    .q           (ir_shift_q)
  );

  tap_shift_reg #(.WIDTH(32)) u_id_shift (
    .tclk        (tclk),
    .trst        (trst),
    .capture     (cap_dr_en & (dr_sel == DR_IDCODE)),
    .shift       (sh_dr_en & (dr_sel == DR_IDCODE)),
    .capture_val (IDCODE_VALUE),
    .tdi         (tdi),
    .q           (id_shift_q)
  );

  always_comb begin
    ir_out_d = ir_out_q;
    if (test_logic_reset) ir_out_d = IR_WIDTH'(OP_IDCODE);
    else if (upd_ir_en)   ir_out_d = ir_shift_q;

    bypass_d = bypass_q;
    if (cap_dr_en && dr_sel == DR_BYPASS)     bypass_d = 1'b0;
    else if (sh_dr_en && dr_sel == DR_BYPASS) bypass_d = tdi;
  end

  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      ir_out_q <= IR_WIDTH'(OP_IDCODE);
      bypass_q <= 1'b0;
    end else begin
      ir_out_q <= ir_out_d;
      bypass_q <= bypass_d;
    end
  end

`ifdef TAP_USER_REG_EN
  logic [USER_WIDTH-1:0] user_shift_q, user_out_q, user_out_d;
  logic                  user_update_q, user_update_d;

  tap_shift_reg #(.WIDTH(USER_WIDTH)) u_user_shift (
    .tclk        (tclk),
    .trst        (trst),
    .capture     (cap_dr_en & (dr_sel == DR_USER)),
    .shift       (sh_dr_en & (dr_sel == DR_USER)),
    .capture_val (user_in),
    .tdi         (tdi),
    .q           (user_shift_q)
  );

  always_comb begin
    user_out_d    = user_out_q;
    user_update_d = 1'b0;
    if (upd_dr_en && dr_sel == DR_USER) begin
      user_out_d    = user_shift_q;
      user_update_d = 1'b1;
    end
  end

  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      user_out_q    <= '0;
      user_update_q <= 1'b0;
    end else begin
      user_out_q    <= user_out_d;
      user_update_q <= user_update_d;
    end
  end

  assign user_out    = user_out_q;
  assign user_update = user_update_q;
  assign user_lsb    = user_shift_q[0];
  assign unused_bits = ^id_shift_q[31:1];
`else
  assign user_out    = '0;
  assign user_update = 1'b0;
  assign user_lsb    = 1'b0;
  assign unused_bits = ^{id_shift_q[31:1], user_in, upd_dr_en};
`endif

  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_shift_q[0];
    end else if (shift_dr) begin
      case (dr_sel)
        DR_IDCODE: tdo = id_shift_q[0];
        DR_USER:   tdo = user_lsb;
        default:   tdo = bypass_q;
      endcase
    end
  end

  assign tdo_en = shift_ir | shift_dr;
  assign ir_out = ir_out_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_scan_regs.sv
`default_nettype none
// ============================================================================
// Module  : tb_tap_scan_regs
// Brief   : Directed scoreboard bench for tap_scan_regs (either TAP_USER_REG_EN build).
// Rev     : 1.0
// ============================================================================
module tb_tap_scan_regs;

  localparam int          IRW = 4;
  localparam int          UW  = 8;
  localparam logic [31:0] IDC = 32'h1234_5093;
`ifdef TAP_USER_REG_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif

  // {tlr, update_ir, update_dr, capture_ir, capture_dr, shift_ir, shift_dr}
  localparam logic [6:0] D_IDLE = 7'b0000000;
  localparam logic [6:0] D_TLR  = 7'b1000000;
  localparam logic [6:0] D_UIR  = 7'b0100000;
  localparam logic [6:0] D_UDR  = 7'b0010000;
  localparam logic [6:0] D_CIR  = 7'b0001000;
  localparam logic [6:0] D_CDR  = 7'b0000100;
  localparam logic [6:0] D_SIR  = 7'b0000010;
  localparam logic [6:0] D_SDR  = 7'b0000001;

  logic           tclk = 1'b0;
  logic           trst, tdi;
  logic           test_logic_reset, capture_dr, shift_dr, update_dr;
  logic           capture_ir, shift_ir, update_ir;
  logic [UW-1:0]  user_in;
  logic           tdo, tdo_en, user_update;
  logic [IRW-1:0] ir_out;
  logic [UW-1:0]  user_out;

  int   n_cmp = 0;
  int   n_err = 0;
  logic sb[$];

  tap_scan_regs #(.IR_WIDTH(IRW), .IDCODE_VALUE(IDC), .USER_WIDTH(UW)) dut (
    .tclk             (tclk),
    .trst             (trst),
    .tdi              (tdi),
    .test_logic_reset (test_logic_reset),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir),
    .user_in          (user_in),
    .tdo              (tdo),
    .tdo_en           (tdo_en),
    .ir_out           (ir_out),
    .user_out         (user_out),
    .user_update      (user_update)
  );

  always #5 tclk = ~tclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check tdo/tdo_en before the next rising edge.
  task automatic tick(input logic [6:0] dec, input logic d);
    logic e;
    @(negedge tclk);
    {test_logic_reset, update_ir, update_dr, capture_ir, capture_dr, shift_ir, shift_dr} = dec;
    tdi = d;
    #1;
    chk("tdo_en", {63'd0, tdo_en}, {63'd0, dec[1] | dec[0]});
    if (dec[1] | dec[0]) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL tdo_sb_empty: observed=%b expected=<none>", tdo);
      end else begin
        e = sb.pop_front();
        chk("tdo", {63'd0, tdo}, {63'd0, e});
      end
    end else begin
      chk("tdo_idle", {63'd0, tdo}, 64'd0);
    end
  endtask

  task automatic ir_scan(input logic [IRW-1:0] val);
    logic [IRW-1:0] cp;
    cp = IRW'(2'b01);
    tick(D_CIR, 1'b0);
    for (int i = 0; i < IRW; i++) begin
      sb.push_back(cp[i]);
      tick(D_SIR, val[i]);
    end
    tick(D_UIR, 1'b0);
    tick(D_IDLE, 1'b0);
    chk("ir_out", 64'(ir_out), 64'(val));
  endtask

  // Expected stream: captured value LSB-first, then tdi delayed by the length.
  task automatic dr_shift(input logic [63:0] cap, input int len, input int n,
                          input logic [63:0] din);
    for (int i = 0; i < n; i++) begin
      if (i < len) sb.push_back(cap[i]);
      else         sb.push_back(din[i-len]);
      tick(D_SDR, din[i]);
    end
  endtask

  task automatic dr_scan(input logic [63:0] cap, input int len, input int n,
                         input logic [63:0] din);
    tick(D_CDR, 1'b0);
    dr_shift(cap, len, n, din);
    tick(D_UDR, 1'b0);
    tick(D_IDLE, 1'b0);
  endtask

  initial begin
    logic [63:0] rnd;
    trst = 1'b1;
    tdi  = 1'b0;
    user_in = '0;
    {test_logic_reset, update_ir, update_dr, capture_ir, capture_dr, shift_ir, shift_dr} = D_IDLE;

    // Reset state
    @(negedge tclk);
    #1;
    chk("rst_ir_out", 64'(ir_out), 64'd1);
    chk("rst_user_out", 64'(user_out), 64'd0);
    chk("rst_user_update", {63'd0, user_update}, 64'd0);
    chk("rst_tdo", {63'd0, tdo}, 64'd0);
    chk("rst_tdo_en", {63'd0, tdo_en}, 64'd0);
    trst = 1'b0;

    // IDCODE selected out of reset
    dr_scan(64'(IDC), 32, 32, 64'd0);
    chk("idcode_user_update", {63'd0, user_update}, 64'd0);
    chk("idcode_user_out", 64'(user_out), 64'd0);

    // IR capture pattern, then BYPASS via all-ones
    ir_scan(4'hF);
    dr_scan(64'd0, 1, 4, 64'b1101);

    // USER scan (BYPASS when the USER DR is not built)
    user_in = 8'hA5;
    ir_scan(4'h2);
    dr_scan(USER_EN ? 64'hA5 : 64'd0, USER_EN ? 8 : 1, 8, 64'h3C);
    chk("user_out", 64'(user_out), USER_EN ? 64'h3C : 64'd0);
    chk("user_update_pulse", {63'd0, user_update}, {63'd0, USER_EN});
    tick(D_IDLE, 1'b0);
    chk("user_update_clear", {63'd0, user_update}, 64'd0);
    chk("user_out_hold", 64'(user_out), USER_EN ? 64'h3C : 64'd0);

    // test_logic_reset restores IDCODE and outranks update_ir
    ir_scan(4'hF);
    tick(D_TLR, 1'b0);
    tick(D_IDLE, 1'b0);
    chk("tlr_ir_out", 64'(ir_out), 64'd1);
    tick(D_TLR | D_UIR, 1'b0);
    tick(D_IDLE, 1'b0);
    chk("tlr_prio_ir_out", 64'(ir_out), 64'd1);
    rnd = {$urandom(), $urandom()};
    dr_scan(64'(IDC), 32, 40, rnd);

    // Undefined opcode behaves as BYPASS
    ir_scan(4'h7);
    dr_scan(64'd0, 1, 6, 64'b100110);
    chk("op7_user_update", {63'd0, user_update}, 64'd0);

    // Asynchronous reset in the middle of a DR shift
    user_in = 8'h5A;
    ir_scan(4'h2);
    tick(D_CDR, 1'b0);
    dr_shift(USER_EN ? 64'h5A : 64'd0, USER_EN ? 8 : 1, 3, 64'b101);
    @(posedge tclk);
    #1;
    trst = 1'b1;
    {test_logic_reset, update_ir, update_dr, capture_ir, capture_dr, shift_ir, shift_dr} = D_IDLE;
    #1;
    chk("trst_ir_out", 64'(ir_out), 64'd1);
    chk("trst_user_out", 64'(user_out), 64'd0);
    chk("trst_user_update", {63'd0, user_update}, 64'd0);
    chk("trst_tdo", {63'd0, tdo}, 64'd0);
    chk("trst_tdo_en", {63'd0, tdo_en}, 64'd0);
    @(negedge tclk);
    trst = 1'b0;
    tick(D_UDR, 1'b0);
    tick(D_IDLE, 1'b0);
    chk("post_trst_user_out", 64'(user_out), 64'd0);
    chk("post_trst_user_update", {63'd0, user_update}, 64'd0);
    rnd = {$urandom(), $urandom()};
    dr_scan(64'(IDC), 32, 34, rnd);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tap_scan_regs.md
Name: tap_scan_regs

Overview:
- JTAG register bank that sits directly downstream of the TAP state controller.
- Consumes the controller's one-hot state decodes and implements the instruction register (IR) and the BYPASS, IDCODE and USER data registers (DRs).
- Muxes the active register onto tdo.
- Exposes the latched instruction and the USER register update to core logic.

Parameters:
- IR_WIDTH, 4: instruction register width in bits; must be >= 2.
- IDCODE_VALUE, 32'h1234_5093: value captured into the IDCODE DR; bit 0 must be 1.
- USER_WIDTH, 8: USER DR width in bits.

Ports:
- tclk  input  1  TCK; every register updates on its rising edge.
- trst  input  1  Asynchronous, active-high reset.
- tdi  input  1  Serial test data in.
- test_logic_reset  input  1  Controller state decode.
- capture_dr  input  1  Controller state decode.
- shift_dr  input  1  Controller state decode.
- update_dr  input  1  Controller state decode.
- capture_ir  input  1  Controller state decode.
- shift_ir  input  1  Controller state decode.
- update_ir  input  1  Controller state decode.
- user_in  input  USER_WIDTH  Parallel value captured into the USER DR.
- tdo  output  1  Serial test data out.
- tdo_en  output  1  High while shifting IR or DR.
- ir_out  output  IR_WIDTH  Latched (active) instruction.
- user_out  output  USER_WIDTH  Last value updated from the USER DR.
- user_update  output  1  One-cycle pulse when user_out loads.

Behaviour:
- Clock and reset (already decided): one clock (tclk); reset trst is asynchronous and active-high.
- Reset values, applied immediately when trst is high:
  - ir_shift = 0; ir_out = OP_IDCODE.
  - bypass_reg = 0; id_shift = 0; user_shift = 0.
  - user_out = 0; user_update = 0.
  - tdo = 0; tdo_en = 0.
- Opcodes:
  - OP_BYPASS = all ones.
  - OP_IDCODE = 1.
  - OP_USER = 2.
  - Any other opcode selects BYPASS.
- Priority on each tclk edge. The inputs are one-hot by contract; if several are high, only the highest-priority one acts:
  - test_logic_reset > update_ir > update_dr > capture_ir > capture_dr > shift_ir > shift_dr.
- test_logic_reset: ir_out <= OP_IDCODE (synchronous). Shift registers are unchanged. user_update = 0.
- capture_ir: ir_shift <= {0..., 2'b01}.
- shift_ir: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}.
- update_ir: ir_out <= ir_shift.
- capture_dr, acting on the DR selected by ir_out:
  - IDCODE: id_shift <= IDCODE_VALUE.
  - BYPASS: bypass_reg <= 0.
  - USER: user_shift <= user_in.
- shift_dr: the selected DR shifts right with tdi entering the MSB. BYPASS is a 1-bit register: bypass_reg <= tdi.
- update_dr:
  - If ir_out = OP_USER: user_out <= user_shift, and user_update is high for exactly the next cycle.
  - If ir_out is anything else: no effect.
- user_update is registered; it is high only in the cycle after an update_dr edge under USER.
- Pause, exit, select and run_test_idle states: no input asserted, so every register holds.
- tdo and tdo_en are combinational from registered state and decodes:
  - shift_ir: tdo = ir_shift[0].
  - shift_dr: tdo = LSB of the selected DR.
  - Otherwise: tdo = 0.
  - tdo_en = shift_ir | shift_dr.
- Shift lengths: IR = IR_WIDTH; IDCODE = 32; USER = USER_WIDTH; BYPASS = 1. The output bit stream is the captured value LSB-first, followed by tdi delayed by the register length.
- ir_out changes only on update_ir, test_logic_reset or trst. A DR scan in progress therefore keeps its selection.
- trst mid-scan aborts the scan:
  - Partial shift data is discarded.
  - user_out is not updated.
  - Scanning resumes normally after trst deasserts.

Optional Feature:
- Macro TAP_USER_REG_EN.
- Defined: the USER instruction and USER DR exist as described above.
- Undefined:
  - OP_USER decodes to BYPASS.
  - user_out stays 0 and user_update stays 0.
  - user_in is ignored.
  - Port list is unchanged.

Decomposition:
- Shared package tap_pkg holds:
  - The controller state encodings.
  - OP_BYPASS, OP_IDCODE, OP_USER.
  - IR_CAPTURE_PATTERN (2'b01).
  - An enum for DR select (DR_BYPASS, DR_IDCODE, DR_USER).
- One sub-module, tap_shift_reg: a generic WIDTH-parameterized capture/shift register with capture, shift, capture_val, tdi and q ports. It is instantiated for the IR, IDCODE and USER registers.

Test Plan:
1. After trst, capture_dr then 32 shift_dr with tdi = 0 -> tdo emits 32'h1234_5093 LSB-first (first bit 1); tdo_en = 1 throughout.
2. capture_ir, then 4 shift_ir with tdi = 1 -> tdo emits 1,0,0,0. update_ir -> ir_out = 4'hF. Then capture_dr and shift tdi = 1,0,1,1 -> tdo = 0,1,0,1.
3. Load IR = 2 with user_in = 8'hA5; capture_dr, then 8 shift_dr with tdi pattern 8'h3C LSB-first -> tdo emits 8'hA5 LSB-first. update_dr -> user_out = 8'h3C; user_update is high for 1 cycle.
4. Load IR = 4'hF, then assert test_logic_reset for 1 cycle -> ir_out = 4'h1. A following DR scan returns IDCODE.
5. Assert trst mid-way through a USER shift -> all outputs take their reset values immediately, with no clock edge required. Afterwards user_out = 0 and user_update stays 0.
6. Load IR = 4'h7 (undefined) -> DR scan behaves as 1-bit BYPASS. With TAP_USER_REG_EN undefined, IR = 2 also behaves as BYPASS.
